// File: rtl/spike_rate_monitor.sv
// Spike-rate monitor: windowed spike count with valid/ready readout, plus continuous ISI measurement.
// Optional burst detector is built only when BURST_DETECT_EN is defined.
module spike_rate_monitor #(
  parameter int unsigned WIN_W     = 8,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned ISI_W     = 8,
  parameter int unsigned BURST_ISI = 3,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] win_len,
  input  logic             ready_in,
  output logic [CNT_W-1:0] rate_out,
  output logic             valid_out,
  output logic             overrun_out,
  output logic [ISI_W-1:0] isi_out,
  output logic             burst_out
);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t             state_q, state_d;
  logic [WIN_W-1:0]   remaining_q, remaining_d;
  logic [CNT_W-1:0]   count_q, count_d, count_inc;
  logic [CNT_W-1:0]   rate_q, rate_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;
  logic [ISI_W-1:0]   isi_cnt_q, isi_cnt_d, isi_inc;
  logic [ISI_W-1:0]   isi_q, isi_d;

  if (BURST_LEN < 2 || BURST_ISI == 0) begin : g_bad_cfg
    $error("spike_rate_monitor: BURST_LEN must be >= 2 and BURST_ISI >= 1");
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    count_d     = count_q;
    rate_d      = rate_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    count_inc   = (count_q == '1) ? count_q : count_q + CNT_W'(spike_in);

    if (valid_q && ready_in) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_len != '0) begin
          remaining_d = win_len;
          count_d     = '0;
          state_d     = COUNT;
        end
      end
      COUNT: begin
        if (remaining_q == WIN_W'(1)) begin
          // A completion overrides the accept-drop above, so valid stays high.
          rate_d      = count_inc;
          valid_d     = 1'b1;
          if (valid_q && !ready_in) overrun_d = 1'b1;
          remaining_d = win_len;
          count_d     = '0;
          if (win_len == '0) state_d = IDLE;
        end else begin
          remaining_d = remaining_q - WIN_W'(1);
          count_d     = count_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    isi_inc   = (isi_cnt_q == '1) ? isi_cnt_q : isi_cnt_q + ISI_W'(1);
    isi_d     = isi_q;
    isi_cnt_d = isi_inc;
    if (spike_in) begin
      isi_d     = isi_inc;
      isi_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      count_q     <= '0;
      rate_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      isi_cnt_q   <= '1;
      isi_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
      rate_q      <= rate_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      isi_cnt_q   <= isi_cnt_d;
      isi_q       <= isi_d;
    end
  end

  assign rate_out    = rate_q;
  assign valid_out   = valid_q;
  assign overrun_out = overrun_q;
  assign isi_out     = isi_q;

`ifdef BURST_DETECT_EN
  localparam int unsigned RUN_W = $clog2(BURST_LEN + 1);

  logic [RUN_W-1:0] run_q, run_d;
  logic [RUN_W:0]   run_inc;
  logic             burst_q, burst_d;

  // run counts consecutive short ISIs; BURST_LEN spikes span BURST_LEN-1 of them.
  always_comb begin
    run_inc = {1'b0, run_q} + (RUN_W + 1)'(1);
    run_d   = run_q;
    burst_d = 1'b0;
    if (spike_in) begin
      if (isi_inc <= ISI_W'(BURST_ISI)) begin
        if (run_inc >= (RUN_W + 1)'(BURST_LEN - 1)) begin
          burst_d = 1'b1;
          run_d   = '0;
        end else begin
          run_d   = run_inc[RUN_W-1:0];
        end
      end else begin
        run_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q   <= '0;
      burst_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      burst_q <= burst_d;
    end
  end

  assign burst_out = burst_q;
`else
  assign burst_out = 1'b0;
`endif

endmodule
